// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU parameters used by the CDB arbiter, RS, RoB and LSB, plus a
// small round-robin helper.
package cdb_arbiter_pkg;

  // Width of a RoB index carried on the common data bus.
  localparam int ROB_WIDTH  = 4;

  // Width of a result word.
  localparam int DATA_WIDTH = 32;

  // Tag meaning "operand has no pending producer": one bit wider than a
  // RoB index so it can never alias a real entry.
  localparam logic [ROB_WIDTH:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};

  // Next highest-priority source after a grant to source g among n sources.
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result queue for the CDB arbiter. A push into a full queue is
// still accepted when the queue is popped on the same edge; otherwise it is
// rejected and reported on o_drop.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int ENTRY_W    = ROB_WIDTH + DATA_WIDTH,
  parameter int FIFO_WIDTH = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_entry,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_drop,
  output logic [ENTRY_W-1:0] o_head
);

  localparam int DEPTH = 1 << FIFO_WIDTH;

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [FIFO_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_WIDTH:0]   r_count;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign o_full    = (r_count == (FIFO_WIDTH+1)'(DEPTH));
  assign o_empty   = (r_count == {(FIFO_WIDTH+1){1'b0}});
  assign w_pop_ok  = i_pop & ~o_empty;
  // When full, a same-edge pop frees the slot the write pointer points at.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_drop    = i_push & ~w_push_ok;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage write; the head slot is read combinationally before this edge.
  always_ff @(posedge clk_in) begin
    if (w_push_ok && !rst_in && !i_clear) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_in) begin
    if (rst_in || i_clear) begin
      r_wr_ptr <= {FIFO_WIDTH{1'b0}};
      r_rd_ptr <= {FIFO_WIDTH{1'b0}};
      r_count  <= {(FIFO_WIDTH+1){1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + {{(FIFO_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + {{(FIFO_WIDTH-1){1'b0}}, 1'b1};
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + {{FIFO_WIDTH{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{FIFO_WIDTH{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per producer, a combinational
// round-robin pick over the non-empty FIFOs, and a registered broadcast of
// at most one result per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int RoB_WIDTH  = ROB_WIDTH,
  parameter int NUM_SRC    = 3,
  parameter int FIFO_WIDTH = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            flush_signal,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*RoB_WIDTH-1:0]    src_index,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]              src_full,
  output logic                            CDB_update_en,
  output logic [RoB_WIDTH-1:0]            CDB_update_index,
  output logic [DATA_WIDTH-1:0]           CDB_update_data,
  output logic                            overflow_err
);

  localparam int ENTRY_W = RoB_WIDTH + DATA_WIDTH;
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                 w_run;
  logic                 w_clear;
  logic [NUM_SRC-1:0]   w_push;
  logic [NUM_SRC-1:0]   w_pop;
  logic [NUM_SRC-1:0]   w_empty;
  logic [NUM_SRC-1:0]   w_drop;
  logic [ENTRY_W-1:0]   w_head [NUM_SRC];
  logic [ENTRY_W-1:0]   w_grant_head;
  logic                 w_grant_valid;
  logic [SRC_W-1:0]     w_grant_src;
  logic [SRC_W-1:0]     w_cand;
  logic [SRC_W-1:0]     w_rr_next;

  logic [SRC_W-1:0]     r_rr_ptr;
  logic                 r_en;
  logic [RoB_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_data;
  logic                 r_ovf;

  // Normal operation vs flush; reset outranks both, pause freezes both.
  assign w_run   = rdy_in & ~flush_signal & ~rst_in;
  assign w_clear = rdy_in &  flush_signal & ~rst_in;
  assign w_push  = src_valid & {NUM_SRC{w_run}};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cdb_fifo #(
      .ENTRY_W    (ENTRY_W),
      .FIFO_WIDTH (FIFO_WIDTH)
    ) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_clear (w_clear),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_entry ({src_index[g*RoB_WIDTH +: RoB_WIDTH], src_data[g*DATA_WIDTH +: DATA_WIDTH]}),
      .o_full  (src_full[g]),
      .o_empty (w_empty[g]),
      .o_drop  (w_drop[g]),
      .o_head  (w_head[g])
    );
  end

  // Round-robin pick: first non-empty FIFO starting at r_rr_ptr.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_src   = {SRC_W{1'b0}};
    w_cand        = {SRC_W{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      w_cand = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      if (!w_grant_valid && !w_empty[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_src   = w_cand;
      end else begin
        w_grant_valid = w_grant_valid;
      end
    end
  end

  // Pop strobe for the granted FIFO, only when the bus actually advances.
  always_comb begin
    w_pop = {NUM_SRC{1'b0}};
    if (w_grant_valid && w_run) begin
      w_pop[w_grant_src] = 1'b1;
    end else begin
      w_pop = {NUM_SRC{1'b0}};
    end
  end

  assign w_grant_head = w_head[w_grant_src];
  assign w_rr_next    = SRC_W'(rr_next(int'(w_grant_src), NUM_SRC));

  // Broadcast registers, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_en     <= 1'b0;
      r_index  <= {RoB_WIDTH{1'b0}};
      r_data   <= {DATA_WIDTH{1'b0}};
      r_ovf    <= 1'b0;
      r_rr_ptr <= {SRC_W{1'b0}};
    end else if (!rdy_in) begin
      r_en     <= r_en;
    end else if (flush_signal) begin
      r_en     <= 1'b0;
      r_rr_ptr <= {SRC_W{1'b0}};
    end else begin
      if (w_grant_valid) begin
        r_en     <= 1'b1;
        r_index  <= w_grant_head[ENTRY_W-1 -: RoB_WIDTH];
        r_data   <= w_grant_head[DATA_WIDTH-1:0];
        r_rr_ptr <= w_rr_next;
      end else begin
        r_en     <= 1'b0;
      end
      r_ovf <= r_ovf | (|w_drop);
    end
  end

  assign CDB_update_en    = r_en;
  assign CDB_update_index = r_index;
  assign CDB_update_data  = r_data;
  assign overflow_err     = r_ovf;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int RW    = 4;
  localparam int NS    = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [RW-1:0] idx;
    logic [31:0]   data;
  } ent_t;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              flush_signal;
  logic [NS-1:0]     src_valid;
  logic [NS*RW-1:0]  src_index;
  logic [NS*32-1:0]  src_data;
  logic [NS-1:0]     src_full;
  logic              CDB_update_en;
  logic [RW-1:0]     CDB_update_index;
  logic [31:0]       CDB_update_data;
  logic              overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  ent_t        mq [NS][$];
  int          m_rr;
  logic        m_en;
  logic [RW-1:0] m_idx;
  logic [31:0] m_data;
  logic        m_ovf;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.RoB_WIDTH(RW), .NUM_SRC(NS), .FIFO_WIDTH(2)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .flush_signal     (flush_signal),
    .src_valid        (src_valid),
    .src_index        (src_index),
    .src_data         (src_data),
    .src_full         (src_full),
    .CDB_update_en    (CDB_update_en),
    .CDB_update_index (CDB_update_index),
    .CDB_update_data  (CDB_update_data),
    .overflow_err     (overflow_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input int idx, input logic [31:0] data);
    ent_t e;
    e.idx  = RW'(idx);
    e.data = data;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(int'($urandom_range(0, 15)), $urandom);
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic rst, input logic rdy, input logic flush,
                      input logic [NS-1:0] v, input ent_t e0, input ent_t e1, input ent_t e2);
    ent_t ea [NS];
    ent_t h;
    int   g;
    int   s;
    ea[0] = e0; ea[1] = e1; ea[2] = e2;
    rst_in       = rst;
    rdy_in       = rdy;
    flush_signal = flush;
    src_valid    = v;
    src_index    = {e2.idx, e1.idx, e0.idx};
    src_data     = {e2.data, e1.data, e0.data};

    if (rst) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_en = 1'b0; m_idx = '0; m_data = '0; m_ovf = 1'b0; m_rr = 0;
    end else if (!rdy) begin
      m_rr = m_rr;
    end else if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_en = 1'b0; m_rr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NS; k++) begin
        s = (m_rr + k) % NS;
        if (g < 0 && mq[s].size() > 0) g = s;
      end
      if (g >= 0) begin
        h = mq[g].pop_front();
        m_en = 1'b1; m_idx = h.idx; m_data = h.data;
        m_rr = (g + 1) % NS;
      end else begin
        m_en = 1'b0;
      end
      for (int i = 0; i < NS; i++) begin
        if (v[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(ea[i]);
          else m_ovf = 1'b1;
        end
      end
    end

    @(posedge clk_in);
    #1;
    check("bus_en", CDB_update_en, m_en);
    check("bus_index", CDB_update_index, m_idx);
    check("bus_data", CDB_update_data, m_data);
    check("overflow", overflow_err, m_ovf);
    for (int i = 0; i < NS; i++)
      check("src_full", src_full[i], (mq[i].size() == DEPTH));
  endtask

  ent_t z;
  int   seen_at;

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 3'b000, z, z, z);
  endtask

  initial begin
    z = '0;
    m_rr = 0; m_en = 1'b0; m_idx = '0; m_data = '0; m_ovf = 1'b0;

    // Reset state
    step(1'b1, 1'b1, 1'b0, 3'b000, z, z, z);
    step(1'b1, 1'b1, 1'b0, 3'b111, rnd_ent(), rnd_ent(), rnd_ent());
    check("reset_en", CDB_update_en, 1'b0);
    check("reset_index", CDB_update_index, 4'd0);
    check("reset_data", CDB_update_data, 32'd0);
    check("reset_ovf", overflow_err, 1'b0);
    check("reset_full", src_full, 3'b000);

    // Single push: broadcast only after the following edge
    step(1'b0, 1'b1, 1'b0, 3'b001, mk(5, 32'h1234_5678), z, z);
    check("single_no_bypass", CDB_update_en, 1'b0);
    idle();
    check("single_en", CDB_update_en, 1'b1);
    check("single_index", CDB_update_index, 4'd5);
    check("single_data", CDB_update_data, 32'h1234_5678);
    idle();
    check("single_done", CDB_update_en, 1'b0);

    // Contention with rr_ptr back at 0
    step(1'b0, 1'b1, 1'b1, 3'b000, z, z, z);
    step(1'b0, 1'b1, 1'b0, 3'b111, mk(1, 32'hA1), mk(2, 32'hA2), mk(3, 32'hA3));
    idle(); check("contend_1", CDB_update_index, 4'd1);
    idle(); check("contend_2", CDB_update_index, 4'd2);
    idle(); check("contend_3", CDB_update_index, 4'd3);
    step(1'b0, 1'b1, 1'b0, 3'b011, mk(4, 32'hB0), mk(6, 32'hB1), z);
    idle(); check("rr_wrapped_to_0", CDB_update_index, 4'd4);
    idle(); check("rr_then_1", CDB_update_index, 4'd6);
    idle();

    // Fairness: source 0 floods, source 1 pushes once
    seen_at = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, {1'b0, (i == 2), 1'b1},
           mk(0, $urandom), mk(9, 32'hFA1F), z);
      if (seen_at < 0 && CDB_update_en && CDB_update_index == 4'd9) seen_at = i;
    end
    check("fairness_latency", (seen_at == 3 || seen_at == 4), 1'b1);
    for (int i = 0; i < 8; i++) idle();

    // Overflow: everyone floods
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 3'b111, rnd_ent(), rnd_ent(), rnd_ent());
    check("ovf_full2", src_full[2], 1'b1);
    check("ovf_set", overflow_err, 1'b1);
    for (int i = 0; i < 12; i++) idle();
    check("ovf_sticky", overflow_err, 1'b1);

    // Flush with simultaneous push
    step(1'b0, 1'b1, 1'b1, 3'b000, z, z, z);
    check("ovf_survives_flush", overflow_err, 1'b1);
    step(1'b0, 1'b1, 1'b0, 3'b111, rnd_ent(), rnd_ent(), rnd_ent());
    step(1'b0, 1'b1, 1'b1, 3'b111, rnd_ent(), rnd_ent(), rnd_ent());
    check("flush_en", CDB_update_en, 1'b0);
    check("flush_full", src_full, 3'b000);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("flush_quiet", CDB_update_en, 1'b0);
    end

    // Pause with queued data, then reset mid-queue
    step(1'b0, 1'b1, 1'b0, 3'b111, mk(7, 32'hC0), mk(8, 32'hC1), mk(10, 32'hC2));
    idle();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, ($urandom_range(0, 1) == 1), 3'($urandom), rnd_ent(), rnd_ent(), rnd_ent());
      check("pause_en", CDB_update_en, 1'b1);
      check("pause_index", CDB_update_index, 4'd7);
    end
    idle();
    check("resume_index", CDB_update_index, 4'd8);
    step(1'b1, 1'b1, 1'b0, 3'b000, z, z, z);
    check("rst_mid_en", CDB_update_en, 1'b0);
    check("rst_mid_index", CDB_update_index, 4'd0);
    check("rst_mid_data", CDB_update_data, 32'd0);
    check("rst_mid_ovf", overflow_err, 1'b0);
    idle();
    check("rst_discards", CDB_update_en, 1'b0);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 4), 3'($urandom),
           rnd_ent(), rnd_ent(), rnd_ent());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter RoB_WIDTH, default 4: width of the RoB index carried on the bus.
REQ-002 Parameter NUM_SRC, default 3: number of producers (0 = RS ALU, 1 = LSB, 2 = branch/jalr unit).
REQ-003 Parameter FIFO_WIDTH, default 2: each per-source FIFO has 1<<FIFO_WIDTH entries.
REQ-004 clk_in  input  1  clock; one clock, all state on its rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 rdy_in  input  1  global run enable; low = pause.
REQ-007 flush_signal  input  1  misprediction flush.
REQ-008 src_valid  input  NUM_SRC  per-source result-valid strobe, one bit per source.
REQ-009 src_index  input  NUM_SRC*RoB_WIDTH  per-source RoB index; source s occupies bits [s*RoB_WIDTH +: RoB_WIDTH].
REQ-010 src_data  input  NUM_SRC*32  per-source result; source s occupies bits [s*32 +: 32].
REQ-011 src_full  output  NUM_SRC  per-source FIFO full (combinational from count).
REQ-012 CDB_update_en  output  1  registered broadcast valid, to RoB, RS and LSB.
REQ-013 CDB_update_index  output  RoB_WIDTH  registered broadcast RoB index.
REQ-014 CDB_update_data  output  32  registered broadcast data.
REQ-015 overflow_err  output  1  sticky flag: a result was dropped.

Function
REQ-016 At most one result SHALL be broadcast per cycle; the bus is the shared resource and the block arbitrates among NUM_SRC producers.
REQ-017 Each source SHALL own one FIFO; src_valid[s] high pushes {index, data} of source s in that cycle.
REQ-018 A push SHALL be accepted when count < depth, or when count == depth and that FIFO is popped in the same cycle (net count unchanged).
REQ-019 A push to a full FIFO that is not popped SHALL be dropped, SHALL set overflow_err, and SHALL leave the FIFO unchanged.
REQ-020 Arbitration SHALL be round-robin: rr_ptr names the highest-priority source; the grant goes to the first non-empty FIFO searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
REQ-021 After a grant to source g, rr_ptr SHALL become (g+1) mod NUM_SRC; with no grant, rr_ptr SHALL hold.
REQ-022 A granted entry SHALL be popped, and on the same edge CDB_update_en<=1 with that entry's index and data.
REQ-023 With no non-empty FIFO, CDB_update_en SHALL be 0, and index and data SHALL hold their last values.
REQ-024 Latency: a push at edge N SHALL be broadcast no earlier than after edge N+1; there is no input-to-bus bypass.
REQ-025 FIFO order SHALL be preserved within a source; there is no ordering guarantee across sources.
REQ-026 FIFO pointers SHALL wrap modulo depth; count ranges 0..depth.
REQ-027 While rdy_in=0, all state and outputs SHALL hold, and src_valid SHALL be ignored.
REQ-028 When flush_signal=1 and rdy_in=1: all FIFOs emptied, CDB_update_en<=0, rr_ptr<=0, pushes that cycle discarded; overflow_err holds.
REQ-029 Priority of control inputs: rst_in over rdy_in=0 over flush_signal over normal operation.

Reset
REQ-030 On rst_in=1 the block SHALL set CDB_update_en=0, CDB_update_index=0, CDB_update_data=0, overflow_err=0, rr_ptr=0, and all FIFO pointers and counts to 0.
REQ-031 Reset during a pending broadcast or a partially filled FIFO SHALL discard all contents; the first broadcast after reset needs a new push.

Structure
REQ-032 RoB_WIDTH, NON_DEP and the data width (32) SHALL come from the shared CPU parameter header also used by the RS, RoB and LSB.
REQ-033 The per-source queue SHALL be a sub-module cdb_fifo (push, pop, clear, full, empty, head outputs), instantiated NUM_SRC times with a generate loop.
REQ-034 The round-robin pick SHALL be combinational in cdb_arbiter; only rr_ptr and the output registers are sequential in the top.

Verification
REQ-035 Single push: src_valid=001, index 5, data 0x12345678 at edge N -> CDB_update_en=1, index 5, data 0x12345678 after edge N+1 only, then en=0.
REQ-036 Contention: all three sources push in one cycle (indices 1, 2, 3) with rr_ptr=0 -> broadcasts 1, 2, 3 on consecutive cycles, and rr_ptr ends at 0.
REQ-037 Fairness: source 0 pushes every cycle and source 1 pushes once -> source 1 is broadcast within 2 cycles of its push.
REQ-038 Overflow: 5 pushes to source 2 in consecutive cycles while sources 0 and 1 flood -> src_full[2]=1, a push while full and not granted is dropped, overflow_err=1 stays set until rst_in.
REQ-039 Flush: 3 entries queued, flush_signal=1 with a simultaneous push -> next cycle CDB_update_en=0, all src_full=0, nothing broadcast afterwards.
REQ-040 Pause and reset: rdy_in=0 for 4 cycles with queued data -> outputs frozen and no pops; rst_in mid-queue -> all outputs 0 on the next cycle.
